// File: rtl/chacha_block_sequencer_if.sv
// Job control, quarter-round unit and keystream handshake signals of the ChaCha20 block sequencer.
// slave is the sequencer's view; master is the environment's view (host, QR unit, consumer).
interface chacha_block_sequencer_if;
  logic         start;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  counter_init;
  logic [15:0]  num_blocks;
  logic         busy;
  logic         done;
  logic         ctr_err;
  logic         qr_start;
  logic [31:0]  qr_a, qr_b, qr_c, qr_d;
  logic         qr_done;
  logic [31:0]  qr_ra, qr_rb, qr_rc, qr_rd;
  logic         ks_valid;
  logic         ks_ready;
  logic [511:0] ks_data;
  logic [31:0]  ks_counter;

  modport slave (
    input  start, key, nonce, counter_init, num_blocks,
    output busy, done, ctr_err,
    output qr_start, qr_a, qr_b, qr_c, qr_d,
    input  qr_done, qr_ra, qr_rb, qr_rc, qr_rd,
    output ks_valid, ks_data, ks_counter,
    input  ks_ready
  );

  modport master (
    output start, key, nonce, counter_init, num_blocks,
    input  busy, done, ctr_err,
    input  qr_start, qr_a, qr_b, qr_c, qr_d,
    output qr_done, qr_ra, qr_rb, qr_rc, qr_rd,
    input  ks_valid, ks_data, ks_counter,
    output ks_ready
  );
endinterface

// File: rtl/chacha_block_sequencer.sv
// ChaCha20 block sequencer: builds the state, drives a shared quarter-round unit through
// DOUBLE_ROUNDS column/diagonal passes, feed-forward adds and hands out 512-bit keystream blocks.
module chacha_block_sequencer #(
  parameter int unsigned DOUBLE_ROUNDS = 10
) (
  input logic clk,
  input logic rst_n,
  chacha_block_sequencer_if.slave bus
);

  localparam int unsigned RW = (DOUBLE_ROUNDS > 1) ? $clog2(DOUBLE_ROUNDS) : 1;
  localparam logic [RW-1:0] LAST_ROUND = RW'(DOUBLE_ROUNDS - 1);
  localparam logic [127:0] SIGMA = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_ISSUE, S_WAIT, S_FINAL, S_OUT, S_DONE
  } state_t;

  state_t             state;
  logic [255:0]       key_q;
  logic [95:0]        nonce_q;
  logic [31:0]        ctr_q;
  logic [15:0]        blocks_left;
  logic [15:0][31:0]  init_m;
  logic [15:0][31:0]  work;
  logic [2:0]         qidx;
  logic [RW-1:0]      round;

  logic [15:0][31:0]  build_m;
  logic [15:0][31:0]  work_wr;
  logic [15:0][31:0]  sum;
  logic [3:0]         ia, ib, ic, id;
  logic [3:0]         na, nb, nc, nd;
  logic [2:0]         qnext;

  // Word indices {a,b,c,d} for quarter-round slot q: four columns, then four diagonals.
  function automatic logic [15:0] qr_words(input logic [2:0] q);
    case (q)
      3'd0:    qr_words = {4'd0, 4'd4, 4'd8,  4'd12};
      3'd1:    qr_words = {4'd1, 4'd5, 4'd9,  4'd13};
      3'd2:    qr_words = {4'd2, 4'd6, 4'd10, 4'd14};
      3'd3:    qr_words = {4'd3, 4'd7, 4'd11, 4'd15};
      3'd4:    qr_words = {4'd0, 4'd5, 4'd10, 4'd15};
      3'd5:    qr_words = {4'd1, 4'd6, 4'd11, 4'd12};
      3'd6:    qr_words = {4'd2, 4'd7, 4'd8,  4'd13};
      default: qr_words = {4'd3, 4'd4, 4'd9,  4'd14};
    endcase
  endfunction

  always_comb begin
    build_m = {nonce_q, ctr_q, key_q, SIGMA};
    {ia, ib, ic, id} = qr_words(qidx);
    qnext = qidx + 3'd1;
    {na, nb, nc, nd} = qr_words(qnext);
    // Next operands are read from the post-writeback view so ISSUE follows WAIT with no bubble.
    work_wr = work;
    work_wr[ia] = bus.qr_ra;
    work_wr[ib] = bus.qr_rb;
    work_wr[ic] = bus.qr_rc;
    work_wr[id] = bus.qr_rd;
    for (int unsigned w = 0; w < 16; w++) begin
      sum[4'(w)] = work[4'(w)] + init_m[4'(w)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      key_q          <= '0;
      nonce_q        <= '0;
      ctr_q          <= '0;
      blocks_left    <= '0;
      init_m         <= '0;
      work           <= '0;
      qidx           <= '0;
      round          <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.ctr_err    <= 1'b0;
      bus.qr_start   <= 1'b0;
      bus.qr_a       <= '0;
      bus.qr_b       <= '0;
      bus.qr_c       <= '0;
      bus.qr_d       <= '0;
      bus.ks_valid   <= 1'b0;
      bus.ks_data    <= '0;
      bus.ks_counter <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            key_q       <= bus.key;
            nonce_q     <= bus.nonce;
            ctr_q       <= bus.counter_init;
            blocks_left <= bus.num_blocks;
            bus.busy    <= 1'b1;
            bus.ctr_err <= 1'b0;
            state       <= S_INIT;
          end
        end
        S_INIT: begin
          init_m <= build_m;
          work   <= build_m;
          qidx   <= '0;
          round  <= '0;
          if (blocks_left == 16'd0) begin
            bus.done <= 1'b1;
            state    <= S_DONE;
          end else begin
            bus.qr_start <= 1'b1;
            bus.qr_a     <= build_m[0];
            bus.qr_b     <= build_m[4];
            bus.qr_c     <= build_m[8];
            bus.qr_d     <= build_m[12];
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          bus.qr_start <= 1'b0;
          state        <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.qr_done) begin
            work <= work_wr;
            qidx <= qnext;
            if (qidx == 3'd7 && round == LAST_ROUND) begin
              state <= S_FINAL;
            end else begin
              if (qidx == 3'd7) round <= round + 1'b1;
              bus.qr_start <= 1'b1;
              bus.qr_a     <= work_wr[na];
              bus.qr_b     <= work_wr[nb];
              bus.qr_c     <= work_wr[nc];
              bus.qr_d     <= work_wr[nd];
              state        <= S_ISSUE;
            end
          end
        end
        S_FINAL: begin
          bus.ks_data    <= sum;
          bus.ks_counter <= ctr_q;
          bus.ks_valid   <= 1'b1;
          state          <= S_OUT;
        end
        S_OUT: begin
          if (bus.ks_ready) begin
            bus.ks_valid <= 1'b0;
            blocks_left  <= blocks_left - 16'd1;
            if (blocks_left == 16'd1) begin
              bus.done <= 1'b1;
              state    <= S_DONE;
            end else if (ctr_q == 32'hFFFF_FFFF) begin
              bus.ctr_err <= 1'b1;
              bus.done    <= 1'b1;
              state       <= S_DONE;
            end else begin
              ctr_q <= ctr_q + 32'd1;
              state <= S_INIT;
            end
          end
        end
        S_DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_block_sequencer.sv
// Self-checking bench for chacha_block_sequencer: behavioural QR unit, keystream consumer,
// table of jobs checked against a reference ChaCha20 block function, plus corner sequences.
module tb_chacha_block_sequencer;
  localparam int DR = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chacha_block_sequencer_if bus();
  chacha_block_sequencer #(.DOUBLE_ROUNDS(DR)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_i(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference ChaCha20 block
  int qt [8][4] = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
                    '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};

  function automatic logic [127:0] qr_f(input logic [31:0] a, b, c, d);
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n,
                                             input logic [31:0] c);
    logic [31:0] s [16];
    logic [31:0] x [16];
    logic [511:0] o;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
    x = s;
    for (int r = 0; r < DR; r++) begin
      for (int q = 0; q < 8; q++) begin
        {x[qt[q][0]], x[qt[q][1]], x[qt[q][2]], x[qt[q][3]]} =
          qr_f(x[qt[q][0]], x[qt[q][1]], x[qt[q][2]], x[qt[q][3]]);
      end
    end
    for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i] + s[i];
    return o;
  endfunction

  // Environment configuration
  bit rnd_mode = 1'b0;
  int stall_cfg = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Quarter-round unit: fixed 1-cycle or random 1-7 cycle latency with spurious qr_done pulses
  logic [31:0] pa, pb, pc, pd;
  bit pending = 1'b0;
  int pend_cnt = 0;
  initial begin
    bus.qr_done = 1'b0;
    bus.qr_ra = '0; bus.qr_rb = '0; bus.qr_rc = '0; bus.qr_rd = '0;
    forever begin
      @(posedge clk); #1;
      bus.qr_done = 1'b0;
      if (!rst_n) begin
        pending = 1'b0;
      end else if (pending) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          {bus.qr_ra, bus.qr_rb, bus.qr_rc, bus.qr_rd} = qr_f(pa, pb, pc, pd);
          bus.qr_done = 1'b1;
          pending = 1'b0;
        end
      end else if (bus.qr_start) begin
        pa = bus.qr_a; pb = bus.qr_b; pc = bus.qr_c; pd = bus.qr_d;
        pending = 1'b1;
        pend_cnt = rnd_mode ? int'($urandom_range(7, 1)) : 1;
        if (rnd_mode && $urandom_range(1, 0) == 1) begin
          bus.qr_done = 1'b1;
          bus.qr_ra = $urandom; bus.qr_rb = $urandom; bus.qr_rc = $urandom; bus.qr_rd = $urandom;
        end
      end else if (rnd_mode && bus.ks_valid && $urandom_range(2, 0) == 0) begin
        bus.qr_done = 1'b1;
        bus.qr_ra = $urandom; bus.qr_rb = $urandom; bus.qr_rc = $urandom; bus.qr_rd = $urandom;
      end
    end
  end

  // Consumer: ks_ready low for stall_cfg cycles of each valid block, noise while idle in random mode
  int rdy_cnt = 0;
  initial begin
    bus.ks_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.ks_valid) begin
        if (rdy_cnt >= stall_cfg) bus.ks_ready = 1'b1;
        else begin bus.ks_ready = 1'b0; rdy_cnt++; end
      end else begin
        rdy_cnt = 0;
        bus.ks_ready = rnd_mode ? 1'($urandom_range(1, 0)) : 1'b0;
      end
    end
  end

  // Monitor (sole writer of the event counters below)
  int n_qrs = 0, n_done = 0, n_hs = 0, n_vr = 0, stab_err = 0;
  logic [127:0] first_qr [32];
  int           qr_mark = 0;
  logic [511:0] hs_data [32];
  logic [31:0]  hs_ctr [32];
  int           vrise [32];
  bit           prev_v = 1'b0, prev_hold = 1'b0;
  logic [511:0] prev_data;
  logic [31:0]  prev_ctr;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (bus.qr_start) begin
        if (n_qrs == qr_mark) first_qr[0] = {bus.qr_a, bus.qr_b, bus.qr_c, bus.qr_d};
        n_qrs++;
      end
      if (bus.done) n_done++;
      if (bus.ks_valid && !prev_v) begin
        if (n_vr < 32) vrise[n_vr] = cyc;
        n_vr++;
      end
      if (bus.ks_valid) begin
        if (prev_hold && (bus.ks_data !== prev_data || bus.ks_counter !== prev_ctr)) stab_err++;
        if (bus.ks_ready) begin
          if (n_hs < 32) begin hs_data[n_hs] = bus.ks_data; hs_ctr[n_hs] = bus.ks_counter; end
          n_hs++;
          prev_hold = 1'b0;
        end else begin
          prev_hold = 1'b1;
          prev_data = bus.ks_data;
          prev_ctr = bus.ks_counter;
        end
      end else begin
        prev_hold = 1'b0;
      end
      prev_v = bus.ks_valid;
    end
  end

  // Job helpers
  int b_qrs, b_hs, b_done, b_vr, b_stab, start_cyc;
  logic [255:0] key_v;
  logic [95:0]  nonce_v;

  task automatic launch(input logic [31:0] c, input logic [15:0] n, input int stall, input bit rnd);
    stall_cfg = stall;
    rnd_mode = rnd;
    b_qrs = n_qrs; b_hs = n_hs; b_done = n_done; b_vr = n_vr; b_stab = stab_err;
    qr_mark = n_qrs;
    bus.counter_init = c;
    bus.num_blocks = n;
    bus.start = 1'b1;
    @(posedge clk); #1;
    start_cyc = cyc;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (n_done == b_done && k < 6000) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_i({tag, " done_pulses"}, n_done - b_done, 1);
    chk_i({tag, " busy_after_done"}, int'(bus.busy), 0);
  endtask

  typedef struct {
    logic [31:0] ctr;
    logic [15:0] n;
    int          stall;
    bit          rnd;
    bit          rfc;
    int          exp_hs;
    bit          exp_err;
  } vec_t;

  vec_t vt [6];
  logic [127:0] rfc_words, rfc_qr;
  logic [31:0]  ectr;
  string        tag;
  int           k;

  initial begin
    vt[0] = '{32'd1,           16'd1, 0,  1'b0, 1'b1, 1, 1'b0};
    vt[1] = '{32'd1,           16'd3, 20, 1'b0, 1'b0, 3, 1'b0};
    vt[2] = '{32'hFFFF_FFFE,   16'd4, 0,  1'b0, 1'b0, 2, 1'b1};
    vt[3] = '{32'd5,           16'd0, 0,  1'b0, 1'b0, 0, 1'b0};
    vt[4] = '{32'd1,           16'd1, 0,  1'b1, 1'b1, 1, 1'b0};
    vt[5] = '{32'hFFFF_FFFF,   16'd1, 5,  1'b1, 1'b0, 1, 1'b0};
    rfc_words = {32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110};
    rfc_qr    = {32'h61707865, 32'h03020100, 32'h13121110, 32'h00000001};

    for (int i = 0; i < 32; i++) key_v[8*i +: 8] = 8'(i);
    nonce_v = '0;
    nonce_v[31:24] = 8'h09;
    nonce_v[63:56] = 8'h4a;
    bus.start = 1'b0;
    bus.key = key_v;
    bus.nonce = nonce_v;
    bus.counter_init = '0;
    bus.num_blocks = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_i("rst busy", int'(bus.busy), 0);
    chk_i("rst done", int'(bus.done), 0);
    chk_i("rst ctr_err", int'(bus.ctr_err), 0);
    chk_i("rst qr_start", int'(bus.qr_start), 0);
    chk_w("rst qr_ops", {384'd0, bus.qr_a, bus.qr_b, bus.qr_c, bus.qr_d}, '0);
    chk_i("rst ks_valid", int'(bus.ks_valid), 0);
    chk_w("rst ks_data", bus.ks_data, '0);
    chk_w("rst ks_counter", {480'd0, bus.ks_counter}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven jobs
    for (int i = 0; i < 6; i++) begin
      tag = $sformatf("vec%0d", i);
      launch(vt[i].ctr, vt[i].n, vt[i].stall, vt[i].rnd);
      chk_i({tag, " busy_after_start"}, int'(bus.busy), 1);
      wait_done(tag);
      chk_i({tag, " handshakes"}, n_hs - b_hs, vt[i].exp_hs);
      chk_i({tag, " valid_rises"}, n_vr - b_vr, vt[i].exp_hs);
      chk_i({tag, " qr_starts"}, n_qrs - b_qrs, vt[i].exp_hs * 8 * DR);
      chk_i({tag, " ctr_err"}, int'(bus.ctr_err), int'(vt[i].exp_err));
      chk_i({tag, " stall_stability"}, stab_err - b_stab, 0);
      for (int j = 0; j < vt[i].exp_hs && j < n_hs - b_hs; j++) begin
        ectr = vt[i].ctr + 32'(j);
        chk_w($sformatf("%s ks_counter%0d", tag, j), {480'd0, hs_ctr[b_hs + j]}, {480'd0, ectr});
        chk_w($sformatf("%s ks_data%0d", tag, j), hs_data[b_hs + j], ref_block(key_v, nonce_v, ectr));
      end
      if (vt[i].rfc) begin
        chk_w({tag, " first_qr_ops"}, {384'd0, first_qr[0]}, {384'd0, rfc_qr});
        chk_w({tag, " rfc_words0_3"}, {384'd0, hs_data[b_hs][127:0]}, {384'd0, rfc_words});
      end
      if (vt[i].exp_hs > 0 && !vt[i].rnd) begin
        chk_i({tag, " latency"}, vrise[b_vr] - start_cyc, 162);
      end
    end

    // Start and changed inputs while busy are ignored
    launch(32'd1, 16'd1, 0, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    bus.counter_init = 32'd7;
    bus.num_blocks = 16'd5;
    bus.key = ~key_v;
    bus.start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("busy_start");
    bus.key = key_v;
    chk_i("busy_start handshakes", n_hs - b_hs, 1);
    chk_w("busy_start ks_counter", {480'd0, hs_ctr[b_hs]}, {480'd0, 32'd1});
    chk_w("busy_start ks_data", hs_data[b_hs], ref_block(key_v, nonce_v, 32'd1));

    // Asynchronous reset while waiting on a QR in double round 5
    launch(32'd1, 16'd1, 0, 1'b0);
    k = 0;
    while (n_qrs - b_qrs < 42 && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    chk_i("midreset reached_round5", n_qrs - b_qrs, 42);
    #2;
    rst_n = 1'b0;
    #1;
    chk_i("midreset busy", int'(bus.busy), 0);
    chk_i("midreset qr_start", int'(bus.qr_start), 0);
    chk_w("midreset qr_ops", {384'd0, bus.qr_a, bus.qr_b, bus.qr_c, bus.qr_d}, '0);
    chk_i("midreset ks_valid", int'(bus.ks_valid), 0);
    chk_w("midreset ks_counter", {480'd0, bus.ks_counter}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk_i("midreset no_done", n_done - b_done, 0);
    chk_i("midreset idle", int'(bus.busy), 0);
    launch(32'd1, 16'd1, 0, 1'b0);
    wait_done("after_reset");
    chk_i("after_reset handshakes", n_hs - b_hs, 1);
    chk_w("after_reset ks_data", hs_data[b_hs], ref_block(key_v, nonce_v, 32'd1));
    chk_w("after_reset rfc_words0_3", {384'd0, hs_data[b_hs][127:0]}, {384'd0, rfc_words});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
